mmc1_mapper: RTL and testbench

MMC1_MAPPER -- requirements
Module: mmc1_mapper

---
 rtl/mmc1_mapper.sv | 150 +++++++++++++++
 tb/tb_mmc1_mapper.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc1_mapper.sv
// MMC1 cartridge mapper: serial-loaded bank registers plus PRG/CHR address
// translation and nametable mirroring.
// Optional build macro: MMC1_WRITE_FILTER_EN adds a flag that remembers
// whether the previous enabled CPU cycle was a mapper write. A write on the
// cycle right after another is dropped, so the dummy write of a
// read-modify-write instruction does not shift a second bit.
module mmc1_mapper #(
  parameter int PRG_BANK_W = 4,
  parameter int CHR_BANK_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [31:0] flags,
  input  logic [15:0] prg_ain,
  output logic [21:0] prg_aout,
  input  logic        prg_read,
  input  logic        prg_write,
  input  logic [7:0]  prg_din,
  output logic        prg_allow,
  input  logic [13:0] chr_ain,
  output logic [21:0] chr_aout,
  output logic        chr_allow,
  output logic        vram_a10,
  output logic        vram_ce
);

  logic [4:0] r_shift;
  logic [4:0] r_control;
  logic [4:0] r_chr0;
  logic [4:0] r_chr1;
  logic [4:0] r_prg;

  logic       w_wr_qual;
  logic [4:0] w_shift_next;

`ifdef MMC1_WRITE_FILTER_EN
  logic r_last_wr;

  // Remember whether the last enabled cycle was a write into mapper space.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_wr <= 1'b0;
    end else if (ce) begin
      r_last_wr <= prg_write && prg_ain[15];
    end
  end

  assign w_wr_qual = ce && prg_write && prg_ain[15] && !r_last_wr;
`else
  assign w_wr_qual = ce && prg_write && prg_ain[15];
`endif

  // Incoming bit enters at the top; the marker bit reaching bit 0 means
  // this write supplies the fifth bit.
  assign w_shift_next = {prg_din[0], r_shift[4:1]};

  // Serial register loading; reset wins over any write on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= 5'b10000;
      r_control <= 5'h0C;
      r_chr0    <= 5'd0;
      r_chr1    <= 5'd0;
      r_prg     <= 5'd0;
    end else if (w_wr_qual) begin
      if (prg_din[7]) begin
        r_shift   <= 5'b10000;
        r_control <= r_control | 5'h0C;
      end else if (!r_shift[0]) begin
        r_shift <= w_shift_next;
      end else begin
        r_shift <= 5'b10000;
        case (prg_ain[14:13])
          2'd0:    r_control <= w_shift_next;
          2'd1:    r_chr0    <= w_shift_next;
          2'd2:    r_chr1    <= w_shift_next;
          default: r_prg     <= w_shift_next;
        endcase
      end
    end
  end

  logic [3:0]            w_prg_bank_full;
  logic [PRG_BANK_W-1:0] w_prg_bank;
  logic [21:0]           w_prg_rom_addr;
  logic                  w_prg_ram_sel;

  // PRG 16 KB bank selection by control[3:2] mode.
  always_comb begin
    w_prg_bank_full = 4'd0;
    case (r_control[3:2])
      2'd2:    w_prg_bank_full = prg_ain[14] ? r_prg[3:0] : 4'd0;
      2'd3:    w_prg_bank_full = prg_ain[14] ? 4'hF : r_prg[3:0];
      default: w_prg_bank_full = {r_prg[3:1], prg_ain[14]};
    endcase
  end

  assign w_prg_bank     = w_prg_bank_full[PRG_BANK_W-1:0];
  assign w_prg_rom_addr = 22'({w_prg_bank, prg_ain[13:0]});
  assign w_prg_ram_sel  = (prg_ain[15:13] == 3'b011);

  assign prg_aout = w_prg_ram_sel ? {9'b111100000, prg_ain[12:0]} : w_prg_rom_addr;

  // ROM is read-only; work RAM is gated by the enable bit prg[4] (active low).
  always_comb begin
    prg_allow = 1'b0;
    if (prg_ain[15]) begin
      prg_allow = !prg_write;
    end else if (w_prg_ram_sel) begin
      prg_allow = !r_prg[4] && (prg_read || prg_write);
    end
  end

  logic [4:0]            w_chr_bank_full;
  logic [CHR_BANK_W-1:0] w_chr_bank;

  // CHR: one 8 KB bank (pair of 4 KB) or two independent 4 KB banks.
  always_comb begin
    w_chr_bank_full = 5'd0;
    if (r_control[4]) begin
      w_chr_bank_full = chr_ain[12] ? r_chr1 : r_chr0;
    end else begin
      w_chr_bank_full = {r_chr0[4:1], chr_ain[12]};
    end
  end

  assign w_chr_bank = w_chr_bank_full[CHR_BANK_W-1:0];
  assign chr_aout   = {1'b1, 21'({w_chr_bank, chr_ain[11:0]})};
  assign chr_allow  = flags[15];

  // Nametable mirroring: single-screen low/high, vertical, horizontal.
  always_comb begin
    vram_a10 = 1'b0;
    case (r_control[1:0])
      2'd0:    vram_a10 = 1'b0;
      2'd1:    vram_a10 = 1'b1;
      2'd2:    vram_a10 = chr_ain[10];
      default: vram_a10 = chr_ain[11];
    endcase
  end

  assign vram_ce = chr_ain[13];

  // Inputs and bank bits intentionally not used by the address logic.
  logic w_unused;
  assign w_unused = &{1'b0, flags[31:16], flags[14:0], prg_din[6:1],
                      w_prg_bank_full, w_chr_bank_full};

endmodule

// File: tb/tb_mmc1_mapper.sv
module tb_mmc1_mapper;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [31:0] flags;
  logic [15:0] prg_ain;
  logic [21:0] prg_aout;
  logic        prg_read;
  logic        prg_write;
  logic [7:0]  prg_din;
  logic        prg_allow;
  logic [13:0] chr_ain;
  logic [21:0] chr_aout;
  logic        chr_allow;
  logic        vram_a10;
  logic        vram_ce;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mmc1_mapper #(.PRG_BANK_W(4), .CHR_BANK_W(5)) dut (
    .clk(clk), .reset(reset), .ce(ce), .flags(flags),
    .prg_ain(prg_ain), .prg_aout(prg_aout), .prg_read(prg_read),
    .prg_write(prg_write), .prg_din(prg_din), .prg_allow(prg_allow),
    .chr_ain(chr_ain), .chr_aout(chr_aout), .chr_allow(chr_allow),
    .vram_a10(vram_a10), .vram_ce(vram_ce)
  );

  task automatic do_reset();
    reset = 1'b1; ce = 1'b0; prg_write = 1'b0; prg_read = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic c);
    ce = c; prg_ain = a; prg_din = d; prg_write = 1'b1; prg_read = 1'b0;
    @(posedge clk); #1;
    prg_write = 1'b0; ce = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic serial_write(input logic [15:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) cpu_write(a, {7'd0, v[i]}, 1'b1);
  endtask

  task automatic cpu_read(input logic [15:0] a);
    prg_ain = a; prg_read = 1'b1; prg_write = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    cpu_read(16'hC000);
    n_tests++;
    if (prg_aout !== 22'h03C000) begin n_fail++; $display("FAIL reset_c000 got %h exp %h", prg_aout, 22'h03C000); end
    n_tests++;
    if (prg_allow !== 1'b1) begin n_fail++; $display("FAIL reset_rom_allow got %b exp 1", prg_allow); end
    cpu_read(16'h8000);
    n_tests++;
    if (prg_aout !== 22'h000000) begin n_fail++; $display("FAIL reset_8000 got %h exp %h", prg_aout, 22'h0); end
    chr_ain = 14'h1234; #1;
    n_tests++;
    if (chr_aout !== 22'h201234) begin n_fail++; $display("FAIL reset_chr got %h exp %h", chr_aout, 22'h201234); end
    n_tests++;
    if (vram_a10 !== 1'b0) begin n_fail++; $display("FAIL reset_a10 got %b exp 0", vram_a10); end
    n_tests++;
    if (chr_allow !== 1'b1) begin n_fail++; $display("FAIL chr_allow got %b exp 1", chr_allow); end
    chr_ain = 14'h2400; #1;
    n_tests++;
    if (vram_ce !== 1'b1) begin n_fail++; $display("FAIL vram_ce got %b exp 1", vram_ce); end
    ce = 1'b0; prg_ain = 16'h8000; prg_write = 1'b1; #1;
    n_tests++;
    if (prg_allow !== 1'b0) begin n_fail++; $display("FAIL rom_write_allow got %b exp 0", prg_allow); end
    prg_write = 1'b0; ce = 1'b1;
  endtask

  task automatic test_prg_load();
    serial_write(16'hE000, 5'b00101);
    cpu_read(16'h8000);
    n_tests++;
    if (prg_aout !== 22'h014000) begin n_fail++; $display("FAIL prg5_8000 got %h exp %h", prg_aout, 22'h014000); end
    cpu_read(16'hC123);
    n_tests++;
    if (prg_aout !== 22'h03C123) begin n_fail++; $display("FAIL prg5_c123 got %h exp %h", prg_aout, 22'h03C123); end
  endtask

  task automatic test_shift_reset();
    serial_write(16'h8000, 5'b10010);
    cpu_read(16'h8000);
    n_tests++;
    if (prg_aout !== 22'h010000) begin n_fail++; $display("FAIL mode32k_8000 got %h exp %h", prg_aout, 22'h010000); end
    cpu_read(16'hC000);
    n_tests++;
    if (prg_aout !== 22'h014000) begin n_fail++; $display("FAIL mode32k_c000 got %h exp %h", prg_aout, 22'h014000); end
    for (int i = 0; i < 3; i++) cpu_write(16'hA000, 8'h01, 1'b1);
    cpu_write(16'h8000, 8'h80, 1'b1);
    cpu_read(16'hC000);
    n_tests++;
    if (prg_aout !== 22'h03C000) begin n_fail++; $display("FAIL shiftrst_c000 got %h exp %h", prg_aout, 22'h03C000); end
    cpu_read(16'h8000);
    n_tests++;
    if (prg_aout !== 22'h014000) begin n_fail++; $display("FAIL shiftrst_8000 got %h exp %h", prg_aout, 22'h014000); end
    chr_ain = 14'h0000; #1;
    n_tests++;
    if (chr_aout !== 22'h200000) begin n_fail++; $display("FAIL chr0_untouched got %h exp %h", chr_aout, 22'h200000); end
  endtask

  task automatic test_chr();
    serial_write(16'hA000, 5'd3);
    serial_write(16'hC000, 5'd7);
    chr_ain = 14'h0000; #1;
    n_tests++;
    if (chr_aout !== 22'h203000) begin n_fail++; $display("FAIL chr4k_lo got %h exp %h", chr_aout, 22'h203000); end
    chr_ain = 14'h1000; #1;
    n_tests++;
    if (chr_aout !== 22'h207000) begin n_fail++; $display("FAIL chr4k_hi got %h exp %h", chr_aout, 22'h207000); end
    chr_ain = 14'h0400; #1;
    n_tests++;
    if (chr_aout !== 22'h203400) begin n_fail++; $display("FAIL chr4k_0400 got %h exp %h", chr_aout, 22'h203400); end
    n_tests++;
    if (vram_a10 !== 1'b1) begin n_fail++; $display("FAIL vert_a10_hi got %b exp 1", vram_a10); end
    chr_ain = 14'h0800; #1;
    n_tests++;
    if (vram_a10 !== 1'b0) begin n_fail++; $display("FAIL vert_a10_lo got %b exp 0", vram_a10); end
    serial_write(16'h8000, 5'h0E);
    chr_ain = 14'h1000; #1;
    n_tests++;
    if (chr_aout !== 22'h203000) begin n_fail++; $display("FAIL chr8k_hi got %h exp %h", chr_aout, 22'h203000); end
    chr_ain = 14'h0000; #1;
    n_tests++;
    if (chr_aout !== 22'h202000) begin n_fail++; $display("FAIL chr8k_lo got %h exp %h", chr_aout, 22'h202000); end
  endtask

  task automatic test_mirroring();
    serial_write(16'h8000, 5'h0D);
    chr_ain = 14'h0000; #1;
    n_tests++;
    if (vram_a10 !== 1'b1) begin n_fail++; $display("FAIL mirror1 got %b exp 1", vram_a10); end
    serial_write(16'h8000, 5'h0F);
    chr_ain = 14'h0800; #1;
    n_tests++;
    if (vram_a10 !== 1'b1) begin n_fail++; $display("FAIL mirror3_hi got %b exp 1", vram_a10); end
    chr_ain = 14'h0400; #1;
    n_tests++;
    if (vram_a10 !== 1'b0) begin n_fail++; $display("FAIL mirror3_lo got %b exp 0", vram_a10); end
  endtask

  task automatic test_prg_ram();
    serial_write(16'hE000, 5'b10000);
    cpu_read(16'h6000);
    n_tests++;
    if (prg_allow !== 1'b0) begin n_fail++; $display("FAIL ram_disabled got %b exp 0", prg_allow); end
    serial_write(16'hE000, 5'b00000);
    cpu_read(16'h6000);
    n_tests++;
    if (prg_allow !== 1'b1) begin n_fail++; $display("FAIL ram_enabled got %b exp 1", prg_allow); end
    n_tests++;
    if (prg_aout !== 22'h3C0000) begin n_fail++; $display("FAIL ram_addr got %h exp %h", prg_aout, 22'h3C0000); end
    cpu_read(16'h7ABC);
    n_tests++;
    if (prg_aout !== 22'h3C1ABC) begin n_fail++; $display("FAIL ram_addr2 got %h exp %h", prg_aout, 22'h3C1ABC); end
    cpu_read(16'h4000);
    n_tests++;
    if (prg_allow !== 1'b0) begin n_fail++; $display("FAIL io_allow got %b exp 0", prg_allow); end
  endtask

  task automatic test_ignored_writes();
    do_reset();
    for (int i = 0; i < 5; i++) cpu_write(16'hE000, 8'h01, 1'b0);
    for (int i = 0; i < 5; i++) cpu_write(16'h6000, 8'h01, 1'b1);
    cpu_read(16'h8000);
    n_tests++;
    if (prg_aout !== 22'h000000) begin n_fail++; $display("FAIL ignored_prg got %h exp %h", prg_aout, 22'h0); end
    serial_write(16'hE000, 5'd3);
    cpu_read(16'h8000);
    n_tests++;
    if (prg_aout !== 22'h00C000) begin n_fail++; $display("FAIL after_ignored got %h exp %h", prg_aout, 22'h00C000); end
  endtask

  task automatic test_reset_mid();
    serial_write(16'h8000, 5'h12);
    for (int i = 0; i < 3; i++) cpu_write(16'hE000, 8'h01, 1'b1);
    reset = 1'b1; ce = 1'b1; prg_ain = 16'hE000; prg_din = 8'h01; prg_write = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; prg_write = 1'b0;
    @(posedge clk); #1;
    cpu_read(16'hC000);
    n_tests++;
    if (prg_aout !== 22'h03C000) begin n_fail++; $display("FAIL midrst_ctrl got %h exp %h", prg_aout, 22'h03C000); end
    serial_write(16'hE000, 5'd6);
    cpu_read(16'h8000);
    n_tests++;
    if (prg_aout !== 22'h018000) begin n_fail++; $display("FAIL midrst_prg got %h exp %h", prg_aout, 22'h018000); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ce = 1'b1; prg_ain = 16'h8000; prg_din = 8'h01; prg_write = 1'b1;
    @(posedge clk); #1;
    prg_din = 8'h00;
    @(posedge clk); #1;
    prg_write = 1'b0;
    @(posedge clk); #1;
    cpu_write(16'h8000, 8'h00, 1'b1);
    cpu_write(16'h8000, 8'h01, 1'b1);
    cpu_write(16'h8000, 8'h00, 1'b1);
    chr_ain = 14'h0000;
    cpu_read(16'hC000);
`ifdef MMC1_WRITE_FILTER_EN
    n_tests++;
    if (vram_a10 !== 1'b0) begin n_fail++; $display("FAIL b2b_a10 got %b exp 0", vram_a10); end
    n_tests++;
    if (prg_aout !== 22'h03C000) begin n_fail++; $display("FAIL b2b_c000 got %h exp %h", prg_aout, 22'h03C000); end
    cpu_write(16'h8000, 8'h00, 1'b1);
    cpu_read(16'hC000);
    n_tests++;
    if (prg_aout !== 22'h004000) begin n_fail++; $display("FAIL b2b_fifth got %h exp %h", prg_aout, 22'h004000); end
    n_tests++;
    if (vram_a10 !== 1'b1) begin n_fail++; $display("FAIL b2b_fifth_a10 got %b exp 1", vram_a10); end
`else
    n_tests++;
    if (vram_a10 !== 1'b1) begin n_fail++; $display("FAIL b2b_a10 got %b exp 1", vram_a10); end
    n_tests++;
    if (prg_aout !== 22'h000000) begin n_fail++; $display("FAIL b2b_c000 got %h exp %h", prg_aout, 22'h0); end
`endif
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; flags = 32'h0000_8000; prg_ain = 16'h0000;
    prg_read = 1'b0; prg_write = 1'b0; prg_din = 8'h00; chr_ain = 14'h0000;
    test_reset();
    test_prg_load();
    test_shift_reset();
    test_chr();
    test_mirroring();
    test_prg_ram();
    test_ignored_writes();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
